lsu: RTL and testbench

LSU -- requirements
Module: lsu

---
 rtl/lsu_if.sv | 21 ++
 rtl/lsu.sv | 195 +++++++++++++++++++
 tb/tb_lsu.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_if.sv
// rtl/lsu_if.sv - data bus between the load/store unit and the memory fabric
interface lsu_if;
    logic        bus_read;
    logic        bus_write;
    logic [31:0] bus_address;
    logic [31:0] bus_writedata;
    logic [3:0]  bus_byteenable;
    logic        bus_waitrequest;
    logic        bus_readdatavalid;
    logic [31:0] bus_readdata;

    modport master (
        output bus_read, bus_write, bus_address, bus_writedata, bus_byteenable,
        input  bus_waitrequest, bus_readdatavalid, bus_readdata
    );

    modport slave (
        input  bus_read, bus_write, bus_address, bus_writedata, bus_byteenable,
        output bus_waitrequest, bus_readdatavalid, bus_readdata
    );
endinterface

// File: rtl/lsu.sv
// rtl/lsu.sv - load/store unit: issues one bus access at a time, tracks load owner EX->MEM
module lsu (
    input  logic        clk,
    input  logic        rst,
    input  logic        lsu_valid,
    input  logic        lsu_mem_read,
    input  logic        lsu_mem_write,
    input  logic [2:0]  lsu_opcode,
    input  logic [31:0] lsu_address,
    input  logic [31:0] lsu_writedata,
    input  logic        ex_stage_run,
    input  logic        mem_stall,
    input  logic        mem_flush,
    output logic        lsu_readdatavalid,
    output logic [31:0] lsu_readdata,
    output logic        lsu_stall_req,
    output logic        lsu_load_misaligned,
    output logic        lsu_store_misaligned,
    lsu_if.master       bus
);
    typedef enum logic [1:0] {IDLE, CMD, RESP} state_t;

    state_t      state_q, state_d;
    logic        issued_q, issued_d;
    logic        owner_ex_q, owner_ex_d;
    logic        in_mem_q, in_mem_d;
    logic        buf_valid_q, buf_valid_d;
    logic [31:0] buf_data_q, buf_data_d;
    logic        cmd_read_q, cmd_read_d;
    logic        cmd_write_q, cmd_write_d;
    logic [31:0] cmd_addr_q, cmd_addr_d;
    logic [31:0] cmd_wdata_q, cmd_wdata_d;
    logic [3:0]  cmd_be_q, cmd_be_d;
    logic [2:0]  ld_op_q, ld_op_d;
    logic [1:0]  ld_off_q, ld_off_d;

    logic        misal, want, issue, accept, resp, consume, buf_free;
    logic [3:0]  ex_be;
    logic [31:0] ex_wdata, resp_ext;

    // Select and extend the addressed byte/halfword of a returned word.
    function automatic logic [31:0] load_extend(input logic [2:0] op, input logic [1:0] off,
                                                input logic [31:0] d);
        logic [7:0]  b;
        logic [15:0] h;
        case (off)
            2'd0:    b = d[7:0];
            2'd1:    b = d[15:8];
            2'd2:    b = d[23:16];
            default: b = d[31:24];
        endcase
        h = off[1] ? d[31:16] : d[15:0];
        case (op)
            3'b000:  load_extend = {{24{b[7]}}, b};
            3'b001:  load_extend = {{16{h[15]}}, h};
            3'b100:  load_extend = {24'h0, b};
            3'b101:  load_extend = {16'h0, h};
            default: load_extend = d;
        endcase
    endfunction

    // Decode the EX request, drive the bus and compute all next-state values.
    always_comb begin
        misal = ((lsu_opcode[1:0] == 2'b01) && lsu_address[0]) ||
                ((lsu_opcode[1:0] == 2'b10) && (lsu_address[1:0] != 2'b00));
        lsu_load_misaligned  = lsu_valid && lsu_mem_read && misal;
        lsu_store_misaligned = lsu_valid && lsu_mem_write && misal;

        case (lsu_opcode[1:0])
            2'b00:   begin ex_be = 4'b0001 << lsu_address[1:0]; ex_wdata = {4{lsu_writedata[7:0]}};  end
            2'b01:   begin ex_be = lsu_address[1] ? 4'b1100 : 4'b0011; ex_wdata = {2{lsu_writedata[15:0]}}; end
            default: begin ex_be = 4'b1111; ex_wdata = lsu_writedata; end
        endcase

        // An EX instruction that has not yet been sent to the bus.
        want = !rst && lsu_valid && (lsu_mem_read || lsu_mem_write) && !misal && !issued_q;
        // A pending buffered result must leave before another load may use the buffer.
        buf_free = !buf_valid_q || (in_mem_q && !mem_stall);
        issue    = want && (state_q == IDLE) && buf_free;
        accept   = (issue || (state_q == CMD)) && !bus.bus_waitrequest;
        resp     = (state_q == RESP) && bus.bus_readdatavalid;
        consume  = in_mem_q && (!mem_stall || mem_flush);
        resp_ext = load_extend(ld_op_q, ld_off_q, bus.bus_readdata);

        bus.bus_read       = 1'b0;
        bus.bus_write      = 1'b0;
        bus.bus_address    = 32'h0;
        bus.bus_writedata  = 32'h0;
        bus.bus_byteenable = 4'h0;
        if (state_q == CMD) begin
            bus.bus_read       = cmd_read_q;
            bus.bus_write      = cmd_write_q;
            bus.bus_address    = cmd_addr_q;
            bus.bus_writedata  = cmd_wdata_q;
            bus.bus_byteenable = cmd_be_q;
        end else if (issue) begin
            bus.bus_read       = lsu_mem_read;
            bus.bus_write      = lsu_mem_write && !lsu_mem_read;
            bus.bus_address    = {lsu_address[31:2], 2'b00};
            bus.bus_writedata  = ex_wdata;
            bus.bus_byteenable = ex_be;
        end

        state_d     = state_q;
        cmd_read_d  = cmd_read_q;
        cmd_write_d = cmd_write_q;
        cmd_addr_d  = cmd_addr_q;
        cmd_wdata_d = cmd_wdata_q;
        cmd_be_d    = cmd_be_q;
        ld_op_d     = ld_op_q;
        ld_off_d    = ld_off_q;
        case (state_q)
            IDLE: if (issue) begin
                cmd_read_d  = bus.bus_read;
                cmd_write_d = bus.bus_write;
                cmd_addr_d  = bus.bus_address;
                cmd_wdata_d = bus.bus_writedata;
                cmd_be_d    = bus.bus_byteenable;
                ld_op_d     = lsu_opcode;
                ld_off_d    = lsu_address[1:0];
                if (bus.bus_waitrequest) state_d = CMD;
                else if (lsu_mem_read)   state_d = RESP;
            end
            CMD:  if (!bus.bus_waitrequest) state_d = cmd_read_q ? RESP : IDLE;
            RESP: if (bus.bus_readdatavalid) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // The issued flag keeps a stalled EX instruction from being sent twice.
        issued_d = ex_stage_run ? 1'b0 : (accept ? 1'b1 : issued_q);

        // Load ownership follows the instruction from EX into MEM.
        owner_ex_d = owner_ex_q;
        in_mem_d   = in_mem_q;
        if (consume) in_mem_d = 1'b0;
        if (owner_ex_q && ex_stage_run) begin
            owner_ex_d = 1'b0;
            in_mem_d   = 1'b1;
        end
        if (issue && lsu_mem_read) begin
            if (ex_stage_run) in_mem_d   = 1'b1;
            else              owner_ex_d = 1'b1;
        end

        // Hold a response that MEM cannot take this cycle; drop it if nobody owns it.
        buf_valid_d = buf_valid_q;
        buf_data_d  = buf_data_q;
        if (consume) buf_valid_d = 1'b0;
        if (resp && (owner_ex_q || (in_mem_q && mem_stall && !mem_flush))) begin
            buf_valid_d = 1'b1;
            buf_data_d  = resp_ext;
        end

        lsu_readdatavalid = in_mem_q && !mem_flush && (buf_valid_q || resp);
        lsu_readdata      = buf_valid_q ? buf_data_q : resp_ext;

        lsu_stall_req = ((state_q == CMD) && bus.bus_waitrequest) ||
                        (want && (state_q == IDLE) && bus.bus_waitrequest) ||
                        (in_mem_q && !buf_valid_q && !resp) ||
                        (want && (state_q == RESP));
    end

    // State and tracking registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            issued_q    <= 1'b0;
            owner_ex_q  <= 1'b0;
            in_mem_q    <= 1'b0;
            buf_valid_q <= 1'b0;
            buf_data_q  <= 32'h0;
            cmd_read_q  <= 1'b0;
            cmd_write_q <= 1'b0;
            cmd_addr_q  <= 32'h0;
            cmd_wdata_q <= 32'h0;
            cmd_be_q    <= 4'h0;
            ld_op_q     <= 3'h0;
            ld_off_q    <= 2'h0;
        end else begin
            state_q     <= state_d;
            issued_q    <= issued_d;
            owner_ex_q  <= owner_ex_d;
            in_mem_q    <= in_mem_d;
            buf_valid_q <= buf_valid_d;
            buf_data_q  <= buf_data_d;
            cmd_read_q  <= cmd_read_d;
            cmd_write_q <= cmd_write_d;
            cmd_addr_q  <= cmd_addr_d;
            cmd_wdata_q <= cmd_wdata_d;
            cmd_be_q    <= cmd_be_d;
            ld_op_q     <= ld_op_d;
            ld_off_q    <= ld_off_d;
        end
    end
endmodule

// File: tb/tb_lsu.sv
// tb/tb_lsu.sv - scoreboard bench for lsu
module tb_lsu;
    logic        clk = 1'b0;
    logic        rst;
    logic        lsu_valid, lsu_mem_read, lsu_mem_write;
    logic [2:0]  lsu_opcode;
    logic [31:0] lsu_address, lsu_writedata;
    logic        ex_stage_run, mem_stall, mem_flush;
    logic        lsu_readdatavalid, lsu_stall_req, lsu_load_misaligned, lsu_store_misaligned;
    logic [31:0] lsu_readdata;

    lsu_if bus_if();

    lsu dut (
        .clk(clk), .rst(rst),
        .lsu_valid(lsu_valid), .lsu_mem_read(lsu_mem_read), .lsu_mem_write(lsu_mem_write),
        .lsu_opcode(lsu_opcode), .lsu_address(lsu_address), .lsu_writedata(lsu_writedata),
        .ex_stage_run(ex_stage_run), .mem_stall(mem_stall), .mem_flush(mem_flush),
        .lsu_readdatavalid(lsu_readdatavalid), .lsu_readdata(lsu_readdata),
        .lsu_stall_req(lsu_stall_req), .lsu_load_misaligned(lsu_load_misaligned),
        .lsu_store_misaligned(lsu_store_misaligned), .bus(bus_if)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } bus_cmd_t;

    bus_cmd_t    bus_q[$];
    logic [31:0] rd_q[$];
    int checks = 0, failures = 0;
    int bus_present_cycles = 0, bus_read_cycles = 0, rdv_cycles = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    // Monitor: compare bus commands and load results against the scoreboard queues.
    always @(negedge clk) begin : monitor
        bus_cmd_t e;
        if (!rst) begin
            if (bus_if.bus_read || bus_if.bus_write) begin
                bus_present_cycles++;
                if (bus_if.bus_read) bus_read_cycles++;
                if (bus_q.size() == 0) begin
                    check("bus_unexpected", 32'(bus_if.bus_read | bus_if.bus_write), 32'd0);
                end else begin
                    e = bus_q[0];
                    check("bus_read",  32'(bus_if.bus_read),  32'(e.rd));
                    check("bus_write", 32'(bus_if.bus_write), 32'(e.wr));
                    check("bus_addr",  bus_if.bus_address,    e.addr);
                    check("bus_be",    32'(bus_if.bus_byteenable), 32'(e.be));
                    if (e.wr) check("bus_wdata", bus_if.bus_writedata, e.wdata);
                    if (!bus_if.bus_waitrequest) void'(bus_q.pop_front());
                end
            end
            if (lsu_readdatavalid) begin
                rdv_cycles++;
                if (rd_q.size() == 0) check("rdv_unexpected", 32'(lsu_readdatavalid), 32'd0);
                else                  check("load_data", lsu_readdata, rd_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        lsu_valid = 0; lsu_mem_read = 0; lsu_mem_write = 0; lsu_opcode = 3'b000;
        lsu_address = 32'h0; lsu_writedata = 32'h0;
        ex_stage_run = 1; mem_stall = 0; mem_flush = 0;
        bus_if.bus_waitrequest = 0; bus_if.bus_readdatavalid = 0; bus_if.bus_readdata = 32'h0;
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [2:0] op,
                         input logic [31:0] addr, input logic [31:0] wd);
        lsu_valid = 1; lsu_mem_read = rd; lsu_mem_write = wr;
        lsu_opcode = op; lsu_address = addr; lsu_writedata = wd;
    endtask

    // Load with immediate acceptance and response one cycle later, EX advancing.
    task automatic simple_load(input string nm, input logic [2:0] op, input logic [31:0] addr,
                               input logic [31:0] rdata, input logic [3:0] be,
                               input logic [31:0] exp);
        int rc0, rv0;
        logic [31:0] waddr;
        rc0 = bus_read_cycles; rv0 = rdv_cycles;
        waddr = {addr[31:2], 2'b00};
        bus_q.push_back('{1'b1, 1'b0, waddr, 32'h0, be});
        rd_q.push_back(exp);
        drive(1, 0, op, addr, 32'h0);
        ex_stage_run = 1;
        @(negedge clk); check({nm, "_stall_issue"}, 32'(lsu_stall_req), 32'd0);
        tick();
        idle_inputs();
        bus_if.bus_readdatavalid = 1; bus_if.bus_readdata = rdata;
        @(negedge clk);
        check({nm, "_stall_resp"}, 32'(lsu_stall_req), 32'd0);
        check({nm, "_rdv"}, 32'(lsu_readdatavalid), 32'd1);
        tick();
        idle_inputs();
        @(negedge clk);
        check({nm, "_read_cycles"}, 32'(bus_read_cycles - rc0), 32'd1);
        check({nm, "_rdv_cycles"}, 32'(rdv_cycles - rv0), 32'd1);
        tick();
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        int sc, p0, rc0, rv0;
        idle_inputs();
        rst = 1;
        tick(); tick();
        @(negedge clk);
        check("rst_bus_read",  32'(bus_if.bus_read),  32'd0);
        check("rst_bus_write", 32'(bus_if.bus_write), 32'd0);
        check("rst_rdv",       32'(lsu_readdatavalid), 32'd0);
        check("rst_stall",     32'(lsu_stall_req),    32'd0);
        tick();
        rst = 0;
        tick();

        simple_load("lw",  3'b010, 32'h100, 32'h8899AABB, 4'b1111, 32'h8899AABB);
        simple_load("lb",  3'b000, 32'h103, 32'h80112233, 4'b1000, 32'hFFFFFF80);
        simple_load("lbu", 3'b100, 32'h103, 32'h80112233, 4'b1000, 32'h00000080);
        simple_load("lbu1",3'b100, 32'h101, 32'h80112233, 4'b0010, 32'h00000022);
        simple_load("lhu", 3'b101, 32'h100, 32'h1234F00D, 4'b0011, 32'h0000F00D);

        // Store halfword held by waitrequest for three cycles.
        bus_q.push_back('{1'b0, 1'b1, 32'h200, 32'hBEEFBEEF, 4'b1100});
        p0 = bus_present_cycles; sc = 0;
        drive(0, 1, 3'b001, 32'h202, 32'h0000BEEF);
        ex_stage_run = 0; bus_if.bus_waitrequest = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); if (lsu_stall_req) sc++;
            tick();
        end
        bus_if.bus_waitrequest = 0; ex_stage_run = 1;
        @(negedge clk); if (lsu_stall_req) sc++;
        tick();
        idle_inputs();
        @(negedge clk);
        check("sh_stall_cycles",   32'(sc), 32'd3);
        check("sh_present_cycles", 32'(bus_present_cycles - p0), 32'd4);
        check("sh_idle_after",     32'(bus_if.bus_write), 32'd0);
        check("sh_bus_q_empty",    32'(bus_q.size()), 32'd0);
        tick();

        // Misaligned accesses raise the flag and never reach the bus.
        drive(1, 0, 3'b010, 32'h101, 32'h0);
        @(negedge clk);
        check("lw_misal_flag", 32'(lsu_load_misaligned), 32'd1);
        check("lw_misal_st",   32'(lsu_store_misaligned), 32'd0);
        check("lw_misal_bus",  32'(bus_if.bus_read), 32'd0);
        tick();
        drive(0, 1, 3'b010, 32'h102, 32'h0);
        @(negedge clk);
        check("sw_misal_flag", 32'(lsu_store_misaligned), 32'd1);
        check("sw_misal_bus",  32'(bus_if.bus_write), 32'd0);
        tick();
        drive(0, 1, 3'b001, 32'h203, 32'h0);
        @(negedge clk); check("sh_misal_flag", 32'(lsu_store_misaligned), 32'd1);
        tick();
        drive(1, 0, 3'b010, 32'h101, 32'h0);
        lsu_valid = 0;
        @(negedge clk); check("misal_needs_valid", 32'(lsu_load_misaligned), 32'd0);
        tick();
        idle_inputs();

        // Load accepted while EX is stalled; response buffered until owner reaches MEM.
        rc0 = bus_read_cycles;
        bus_q.push_back('{1'b1, 1'b0, 32'h100, 32'h0, 4'b1100});
        rd_q.push_back(32'hFFFFABCD);
        drive(1, 0, 3'b001, 32'h102, 32'h0);
        ex_stage_run = 0;
        @(negedge clk); check("buf_issue_stall", 32'(lsu_stall_req), 32'd0);
        tick();
        bus_if.bus_readdatavalid = 1; bus_if.bus_readdata = 32'hABCD1234;
        @(negedge clk);
        check("buf_rdv_t1", 32'(lsu_readdatavalid), 32'd0);
        check("buf_no_reissue", 32'(bus_if.bus_read), 32'd0);
        tick();
        bus_if.bus_readdatavalid = 0;
        @(negedge clk); check("buf_rdv_t2", 32'(lsu_readdatavalid), 32'd0);
        tick();
        ex_stage_run = 1;
        @(negedge clk); check("buf_rdv_t3", 32'(lsu_readdatavalid), 32'd0);
        tick();
        idle_inputs();
        @(negedge clk); check("buf_rdv_mem", 32'(lsu_readdatavalid), 32'd1);
        tick();
        @(negedge clk);
        check("buf_rdv_after", 32'(lsu_readdatavalid), 32'd0);
        check("buf_read_cycles", 32'(bus_read_cycles - rc0), 32'd1);
        tick();

        // Load in MEM flushed before its response arrives.
        rv0 = rdv_cycles;
        bus_q.push_back('{1'b1, 1'b0, 32'h300, 32'h0, 4'b1111});
        drive(1, 0, 3'b010, 32'h300, 32'h0);
        tick();
        idle_inputs(); mem_stall = 1;
        @(negedge clk); check("flush_stall_wait", 32'(lsu_stall_req), 32'd1);
        tick();
        mem_flush = 1;
        @(negedge clk); check("flush_rdv", 32'(lsu_readdatavalid), 32'd0);
        tick();
        mem_flush = 0; mem_stall = 0;
        bus_if.bus_readdatavalid = 1; bus_if.bus_readdata = 32'hDEADBEEF;
        @(negedge clk);
        check("flush_stall_dropped", 32'(lsu_stall_req), 32'd0);
        check("flush_resp_silent",   32'(lsu_readdatavalid), 32'd0);
        tick();
        idle_inputs();
        bus_q.push_back('{1'b0, 1'b1, 32'h400, 32'hA5A5A5A5, 4'b0010});
        drive(0, 1, 3'b000, 32'h401, 32'h000000A5);
        @(negedge clk);
        check("flush_idle_after", 32'(bus_if.bus_write), 32'd1);
        check("flush_rdv_count",  32'(rdv_cycles - rv0), 32'd0);
        tick();
        idle_inputs();

        // Reset during an outstanding load; the late response belongs to nobody.
        bus_q.push_back('{1'b1, 1'b0, 32'h500, 32'h0, 4'b1111});
        drive(1, 0, 3'b010, 32'h500, 32'h0);
        tick();
        idle_inputs(); rst = 1;
        tick();
        rst = 0;
        bus_if.bus_readdatavalid = 1; bus_if.bus_readdata = 32'h11111111;
        @(negedge clk);
        check("rst_mid_rdv",   32'(lsu_readdatavalid), 32'd0);
        check("rst_mid_stall", 32'(lsu_stall_req), 32'd0);
        tick();
        idle_inputs();
        simple_load("lw_post_rst", 3'b010, 32'h504, 32'h11223344, 4'b1111, 32'h11223344);

        check("rd_queue_drained",  32'(rd_q.size()),  32'd0);
        check("bus_queue_drained", 32'(bus_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
